display_value_sampler: RTL and testbench

Upstream feeder for the 4-digit seven-segment display path.
- Takes raw 16-bit ALU results and produces the stable 13-bit `number` that the binary-to-BCD/multiplex stage consumes.
- Rate-limits display updates to a readable refresh tick and saturates values to the 4-digit range.
- Provides a debounced push-button "freeze" that holds the displayed value.

---
 rtl/display_value_sampler.sv | 168 ++++++++++++++++
 tb/tb_display_value_sampler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/display_value_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_value_sampler                                                    |
// | Rate-limited, saturating value feeder for the 4-digit display, with a    |
// | debounced freeze button. Define SIGNED_MAG_EN for two's-complement input.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module display_value_sampler #(
   parameter int SAMPLE_DIV      = 25000000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int MAX_DISPLAY     = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value_in,
   input  logic        in_valid,
   input  logic        btn_freeze,
   output logic [12:0] number,
   output logic        overflow,
   output logic        negative,
   output logic        frozen,
   output logic        update_pulse
);

   localparam int c_PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int c_DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(SAMPLE_DIV - 1);
   localparam logic [c_DW-1:0] c_DB_LAST    = c_DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0]     c_MAX16      = 16'(MAX_DISPLAY);
   localparam logic [12:0]     c_MAX13      = 13'(MAX_DISPLAY);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   logic [c_PW-1:0] r_presc;
   logic [15:0]     r_staging;
   logic            r_pending;
   logic            r_sync1;
   logic            r_sync2;
   logic [1:0]      r_fill;
   logic [c_DW-1:0] r_db_cnt;
   logic            r_stable;
   logic            r_armed;
   state_t          r_state;

   logic [15:0]     w_mag;
   logic            w_neg;
   logic            w_sat;
   logic [12:0]     w_num;
   logic            w_tick;
   logic            w_update;
   logic            w_db_diff;
   logic            w_db_done;
   logic            w_rise;

`ifdef SIGNED_MAG_EN
   // 0x8000 negates to itself, which reads as 32768 unsigned and saturates.
   assign w_mag = r_staging[15] ? (~r_staging + 16'd1) : r_staging;
   assign w_neg = r_staging[15];
`else
   assign w_mag = r_staging;
   assign w_neg = 1'b0;
`endif

   assign w_sat     = (w_mag > c_MAX16);
   assign w_num     = w_sat ? c_MAX13 : w_mag[12:0];
   assign w_tick    = (r_presc == c_PRESC_LAST);
   assign w_update  = w_tick && r_pending && !frozen;
   assign w_db_diff = (r_sync2 != r_stable);
   assign w_db_done = w_db_diff && (r_db_cnt == c_DB_LAST);
   // Toggle on the same edge the debounced level rises.
   assign w_rise    = w_db_done && r_sync2 && r_armed;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_staging <= '0;
         r_pending <= 1'b0;
      end else if (in_valid) begin
         r_staging <= value_in;
         r_pending <= 1'b1;
      end else if (w_update) begin
         r_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         number       <= '0;
         overflow     <= 1'b0;
         negative     <= 1'b0;
         update_pulse <= 1'b0;
      end else begin
         update_pulse <= w_update;
         if (w_update) begin
            number   <= w_num;
            overflow <= w_sat;
            negative <= w_neg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_fill   <= '0;
         r_db_cnt <= '0;
         r_stable <= 1'b0;
         r_armed  <= 1'b0;
      end else begin
         r_sync1 <= btn_freeze;
         r_sync2 <= r_sync1;
         r_fill  <= {r_fill[0], 1'b1};
         if (w_db_done) begin
            r_stable <= r_sync2;
            r_db_cnt <= '0;
         end else if (w_db_diff) begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end else begin
            r_db_cnt <= '0;
         end
         // A button held through reset must be seen released before it can freeze.
         if (r_fill[1] && !r_sync2 && !r_stable) begin
            r_armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
         frozen  <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_rise) begin
                  r_state <= ST_HOLD;
                  frozen  <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (w_rise) begin
                  r_state <= ST_RUN;
                  frozen  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_RUN;
               frozen  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_display_value_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_display_value_sampler                                                 |
// | Scoreboarded directed test of display_value_sampler (SAMPLE_DIV=8,       |
// | DEBOUNCE_CYCLES=4). Revision: 1.0                                        |
// +--------------------------------------------------------------------------+
module tb_display_value_sampler;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value_in;
   logic        in_valid;
   logic        btn_freeze;
   logic [12:0] number;
   logic        overflow;
   logic        negative;
   logic        frozen;
   logic        update_pulse;

   display_value_sampler #(
      .SAMPLE_DIV      (8),
      .DEBOUNCE_CYCLES (4),
      .MAX_DISPLAY     (9999)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .value_in     (value_in),
      .in_valid     (in_valid),
      .btn_freeze   (btn_freeze),
      .number       (number),
      .overflow     (overflow),
      .negative     (negative),
      .frozen       (frozen),
      .update_pulse (update_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [12:0] num;
      logic        ovf;
      logic        neg;
   } exp_t;

   exp_t q[$];
   exp_t mon_x;
   int   checks = 0;
   int   passes = 0;
   int   e = 0;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic void expect_upd(int n, bit o, bit g);
      exp_t x;
      x.num = 13'(n);
      x.ovf = o;
      x.neg = g;
      q.push_back(x);
   endfunction

   // Edge counter e counts rising edges since the last reset release.
   task automatic adv_to(int t);
      if (e < t) begin
         while (e < t) begin
            @(posedge clk);
            e++;
         end
         #1;
      end
   endtask

   task automatic pv(int k, logic [15:0] v);
      adv_to(k - 1);
      value_in = v;
      in_valid = 1'b1;
      adv_to(k);
      in_valid = 1'b0;
   endtask

   task automatic chk_frozen(int k, int exp, string name);
      adv_to(k);
      @(negedge clk);
      chk(name, int'(frozen), exp);
   endtask

   // Monitor: every update strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && update_pulse) begin
         chk("update_pulse_expected", int'(q.size() != 0), 1);
         if (q.size() != 0) begin
            mon_x = q.pop_front();
            chk("number", int'(number), int'(mon_x.num));
            chk("overflow", int'(overflow), int'(mon_x.ovf));
            chk("negative", int'(negative), int'(mon_x.neg));
         end
      end
   end

   initial begin
      reset = 1'b1; value_in = '0; in_valid = 1'b0; btn_freeze = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_number", int'(number), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_negative", int'(negative), 0);
      chk("rst_frozen", int'(frozen), 0);
      chk("rst_update_pulse", int'(update_pulse), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      e = 0;

      // Basic update, then saturation and return below the ceiling.
      pv(2, 16'd1234);   expect_upd(1234, 1'b0, 1'b0);
      pv(18, 16'd12000); expect_upd(9999, 1'b1, 1'b0);
      pv(26, 16'd42);    expect_upd(42, 1'b0, 1'b0);

      // Bouncy press: 1,0,1 then held.
      adv_to(33); btn_freeze = 1'b1;
      adv_to(34); btn_freeze = 1'b0;
      adv_to(35); btn_freeze = 1'b1;
      chk_frozen(40, 0, "frozen_before_debounce");
      chk_frozen(41, 1, "frozen_after_debounce");
      pv(44, 16'd77);
      adv_to(48); @(negedge clk);
      chk("hold_number", int'(number), 42);
      adv_to(49); btn_freeze = 1'b0;
      adv_to(57); btn_freeze = 1'b1;
      chk_frozen(62, 1, "still_frozen");
      chk_frozen(63, 0, "unfrozen");
      expect_upd(77, 1'b0, 1'b0);

      // in_valid coinciding with a tick edge.
      adv_to(65); btn_freeze = 1'b0;
      pv(66, 16'd300); expect_upd(300, 1'b0, 1'b0);
      pv(72, 16'd500); expect_upd(500, 1'b0, 1'b0);

      // Freeze with 42 shown, then reset while held.
      pv(82, 16'd42); expect_upd(42, 1'b0, 1'b0);
      adv_to(89); btn_freeze = 1'b1;
      chk_frozen(95, 1, "frozen_before_reset");
      adv_to(97); reset = 1'b1;
      adv_to(98); reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_number", int'(number), 0);
      chk("mid_rst_frozen", int'(frozen), 0);
      chk("mid_rst_overflow", int'(overflow), 0);
      e = 0;
      chk_frozen(10, 0, "held_no_refreeze");
      adv_to(11); btn_freeze = 1'b0;
      adv_to(19); btn_freeze = 1'b1;
      chk_frozen(24, 0, "repress_pending");
      chk_frozen(25, 1, "repress_frozen");
      adv_to(27); btn_freeze = 1'b0;
      adv_to(35); btn_freeze = 1'b1;
      chk_frozen(41, 0, "unfrozen_again");

      // Sign handling and the exact saturation boundary.
      pv(42, 16'hFF85);
`ifdef SIGNED_MAG_EN
      expect_upd(123, 1'b0, 1'b1);
`else
      expect_upd(9999, 1'b1, 1'b0);
`endif
      adv_to(43); btn_freeze = 1'b0;
      pv(50, 16'h8000);
`ifdef SIGNED_MAG_EN
      expect_upd(9999, 1'b1, 1'b1);
`else
      expect_upd(9999, 1'b1, 1'b0);
`endif
      pv(58, 16'd9999);  expect_upd(9999, 1'b0, 1'b0);
      pv(66, 16'd10000); expect_upd(9999, 1'b1, 1'b0);

      adv_to(80); @(negedge clk);
      chk("pending_expectations", int'(q.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
